// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
// Shared definitions for the raster scanner block.
//   state_t : scanner FSM state encoding (IDLE, SCAN, DONE)
// -----------------------------------------------------------------------------
package raster_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/raster_scanner_index_counter.sv
// -----------------------------------------------------------------------------
// index_counter
// Wrapping up/down index counter used for both the column and row index.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, value -> 0
//   en       : step the counter by one in the selected direction
//   clr      : synchronous clear to 0, wins over en
//   up       : 1 = count up (wrap MAX -> 0), 0 = count down (wrap 0 -> MAX)
//   value    : current index
//   at_limit : value is the last index in the current direction
// -----------------------------------------------------------------------------
module index_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         up,
  output logic [W-1:0] value,
  output logic         at_limit
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign at_limit = up ? (value == MAX_V) : (value == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      if (up) value <= at_limit ? '0    : value + 1'b1;
      else    value <= at_limit ? MAX_V : value - 1'b1;
    end
  end

endmodule

// File: rtl/raster_scanner.sv
// -----------------------------------------------------------------------------
// raster_scanner
// Generates (col,row) raster coordinates over a COLS x ROWS frame with a
// valid/ready handshake. Optional build macro RASTER_SCANNER_SERPENTINE_EN
// makes odd rows scan from COLS-1 down to 0.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : single-cycle request to begin a frame (honoured in IDLE only)
//   clear      : synchronous abort to IDLE, wins over start and handshake
//   continuous : at the frame_end handshake, 1 = wrap straight into a new frame
//   out_ready  : downstream accepts the current coordinate
//   out_valid  : col/row hold a valid coordinate
//   col, row   : current coordinate
//   line_end   : current coordinate is the last of its line
//   frame_end  : current coordinate is the last of the frame
//   busy       : state is not IDLE
// -----------------------------------------------------------------------------
module raster_scanner
  import raster_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int ROWS  = 16,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             continuous,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             line_end,
  output logic             frame_end,
  output logic             busy
);

  state_t state, state_nxt;
  logic   hs;
  logic   col_at, row_at;
  logic   col_en, col_up, row_en, cnt_clr;

  assign hs = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = SCAN;
        SCAN:    if (hs && frame_end && !continuous) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    out_valid = (state == SCAN);
    busy      = (state != IDLE);
  end

  // Counters sit at 0 outside SCAN, and the frame_end handshake returns them
  // to the origin, which is both the continuous wrap and the DONE exit.
  assign cnt_clr = clear | (state == IDLE) | (hs & frame_end);

`ifdef RASTER_SCANNER_SERPENTINE_EN
  // Serpentine: the column index holds across a line change, because the
  // last column of one row is the first column of the next.
  assign col_up = ~row[0];
  assign col_en = hs & ~col_at;
`else
  assign col_up = 1'b1;
  assign col_en = hs;
`endif

  assign row_en    = hs & col_at;
  assign line_end  = out_valid & col_at;
  assign frame_end = line_end & row_at;

  index_counter #(.W(COL_W), .MAX(COLS-1)) u_col_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (col_en),
    .clr      (cnt_clr),
    .up       (col_up),
    .value    (col),
    .at_limit (col_at)
  );

  index_counter #(.W(ROW_W), .MAX(ROWS-1)) u_row_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (row_en),
    .clr      (cnt_clr),
    .up       (1'b1),
    .value    (row),
    .at_limit (row_at)
  );

endmodule

// File: tb/tb_raster_scanner.sv
// -----------------------------------------------------------------------------
// tb_raster_scanner
// Directed bench for raster_scanner (COLS=4, ROWS=3). Expected coordinates are
// queued when a frame is requested and compared as the DUT presents them.
// Follows RASTER_SCANNER_SERPENTINE_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_raster_scanner;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int COL_W = 2;
  localparam int ROW_W = 2;
`ifdef RASTER_SCANNER_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             clear;
  logic             continuous;
  logic             out_ready;
  logic             out_valid;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             line_end;
  logic             frame_end;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [COL_W-1:0] c;
    logic [ROW_W-1:0] r;
    logic             le;
    logic             fe;
  } coord_t;

  coord_t sb[$];

  raster_scanner #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .continuous (continuous),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .col        (col),
    .row        (row),
    .line_end   (line_end),
    .frame_end  (frame_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    coord_t e;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        e.c  = (SERP && (r % 2 == 1)) ? COL_W'(COLS - 1 - c) : COL_W'(c);
        e.r  = ROW_W'(r);
        e.le = (c == COLS - 1);
        e.fe = (c == COLS - 1) && (r == ROWS - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready 1010..., plus a stray start
  task automatic run_pops(input int n, input int mode, input int cont_off_at);
    int     pops = 0;
    int     cyc  = 0;
    coord_t obs;
    while (pops < n && cyc < 4 * n + 10) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      start     = (mode == 1) && (cyc == 3);
      if (pops >= cont_off_at) continuous = 1'b0;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow observed=empty expected=entry");
        break;
      end
      obs = {col, row, line_end, frame_end};
      chk("scan_valid", 32'(out_valid), 32'd1);
      chk("coord", 32'(obs), 32'(sb[0]));
      if (out_ready) begin
        void'(sb.pop_front());
        pops++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("pops_done", 32'(pops), 32'(n));
  endtask

  // After the final handshake: one DONE cycle (start ignored), then IDLE.
  task automatic finish_frame();
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    clear      = 1'b0;
    continuous = 1'b0;
    out_ready  = 1'b0;
    #1;
    chk("reset_outs", 32'({out_valid, col, row, line_end, frame_end, busy}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Single frame, out_ready always high
    push_frame();
    start_frame();
    run_pops(COLS * ROWS, 0, 0);
    finish_frame();

    // Single frame, out_ready toggling, start during SCAN ignored
    push_frame();
    start_frame();
    run_pops(COLS * ROWS, 1, 0);
    finish_frame();

    // Three continuous frames with no gap, continuous dropped in the third
    push_frame();
    push_frame();
    push_frame();
    continuous = 1'b1;
    start_frame();
    run_pops(3 * COLS * ROWS, 0, 2 * COLS * ROWS);
    finish_frame();

    // Clear together with start and a handshake at the 7th coordinate
    push_frame();
    start_frame();
    run_pops(6, 0, 0);
    chk("clr_pre_coord", 32'({col, row, line_end, frame_end}), 32'(sb[0]));
    clear     = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_col", 32'(col), 32'd0);
    chk("clr_row", 32'(row), 32'd0);
    sb.delete();
    push_frame();
    start_frame();
    run_pops(COLS * ROWS, 0, 0);
    finish_frame();

    // Asynchronous reset mid-frame
    push_frame();
    start_frame();
    run_pops(5, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_outs", 32'({out_valid, col, row, line_end, frame_end, busy}), 32'd0);
    #3 rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    push_frame();
    start_frame();
    run_pops(COLS * ROWS, 0, 0);
    finish_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
